// File: rtl/serial_word_feeder.sv
// Serialises handshaked parallel words onto SI/LR for a downstream left/right
// shift register, with an optional idle gap between words and a sent-word counter.
module serial_word_feeder #(
  parameter int   WIDTH   = 8,
  parameter int   GAP     = 0,
  parameter logic IDLE_SI = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_lr,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             SI,
  output logic             LR,
  output logic             busy,
  output logic             done,
  output logic [15:0]      word_cnt
);

  localparam int BW = $clog2(WIDTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             si_q, si_d;
  logic             lr_q, lr_d;
  logic [15:0]      word_cnt_q, word_cnt_d;

  logic last_bit;
  logic last_gap;
  logic accept;

  assign last_bit = (state_q == ST_SHIFT) && (bit_cnt_q == BIT_LAST);
  assign last_gap = (state_q == ST_GAP) && (gap_cnt_q == GAP_LAST);
  assign accept   = din_valid && din_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // An accept can only happen in IDLE or in the final cycle of a frame,
  // so it always restarts SHIFT regardless of the current state.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = ST_SHIFT;
    end else if (last_bit) begin
      state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
    end else if (last_gap) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    din_ready = rst_n && ((state_q == ST_IDLE) || (last_bit && (GAP == 0)) || last_gap);
    busy      = (state_q != ST_IDLE);
    done      = last_bit;
  end

  // The word register is pre-shifted on capture because the first bit is
  // loaded into SI directly from din at the accept edge.
  always_comb begin
    word_d     = word_q;
    bit_cnt_d  = bit_cnt_q;
    lr_d       = lr_q;
    si_d       = IDLE_SI;
    gap_cnt_d  = (state_q == ST_GAP) ? gap_cnt_q + 1'b1 : '0;
    word_cnt_d = last_bit ? word_cnt_q + 16'd1 : word_cnt_q;
    if (accept) begin
      word_d    = din_lr ? (din >> 1) : (din << 1);
      si_d      = din_lr ? din[0] : din[WIDTH-1];
      lr_d      = din_lr;
      bit_cnt_d = '0;
    end else if ((state_q == ST_SHIFT) && !last_bit) begin
      si_d      = lr_q ? word_q[0] : word_q[WIDTH-1];
      word_d    = lr_q ? (word_q >> 1) : (word_q << 1);
      bit_cnt_d = bit_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      word_q     <= '0;
      si_q       <= IDLE_SI;
      lr_q       <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      word_q     <= word_d;
      si_q       <= si_d;
      lr_q       <= lr_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign SI       = si_q;
  assign LR       = lr_q;
  assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Directed bench for serial_word_feeder: one instance with GAP=2, one with GAP=0,
// per-bit expectations queued at accept time and popped as bits appear.
module tb_serial_word_feeder;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       din_lr;
  logic       valid_a, valid_b;

  logic        rdy_a, si_a, lr_a, busy_a, done_a;
  logic        rdy_b, si_b, lr_b, busy_b, done_b;
  logic [15:0] cnt_a, cnt_b;

  logic        rdy_o, si_o, lr_o, busy_o, done_o;
  logic [15:0] cnt_o;

  int sel;
  int total;
  int bad;

  typedef struct packed {
    logic       si;
    logic       lr;
    logic       done;
    logic       rdy;
    logic       last;
    logic [7:0] word;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] dsr;

  serial_word_feeder #(.WIDTH(8), .GAP(2), .IDLE_SI(1'b0)) dut_g2 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_lr(din_lr), .din_valid(valid_a),
    .din_ready(rdy_a), .SI(si_a), .LR(lr_a), .busy(busy_a), .done(done_a),
    .word_cnt(cnt_a)
  );

  serial_word_feeder #(.WIDTH(8), .GAP(0), .IDLE_SI(1'b0)) dut_g0 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_lr(din_lr), .din_valid(valid_b),
    .din_ready(rdy_b), .SI(si_b), .LR(lr_b), .busy(busy_b), .done(done_b),
    .word_cnt(cnt_b)
  );

  assign rdy_o  = (sel == 1) ? rdy_b  : rdy_a;
  assign si_o   = (sel == 1) ? si_b   : si_a;
  assign lr_o   = (sel == 1) ? lr_b   : lr_a;
  assign busy_o = (sel == 1) ? busy_b : busy_a;
  assign done_o = (sel == 1) ? done_b : done_a;
  assign cnt_o  = (sel == 1) ? cnt_b  : cnt_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setValid(input logic v);
    if (sel == 1) valid_b = v;
    else valid_a = v;
  endtask

  task automatic pushWord(input logic lr, input logic [7:0] w);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      e.si   = lr ? w[k] : w[7-k];
      e.lr   = lr;
      e.done = (k == 7);
      e.rdy  = (k == 7) && (sel == 1);
      e.last = (k == 7);
      e.word = w;
      sb.push_back(e);
    end
  endtask

  task automatic applyStimulus(input logic lr, input logic [7:0] w, input bit hold);
    din    = w;
    din_lr = lr;
    setValid(1'b1);
    checkOutput("ready_at_accept", 16'(rdy_o), 16'd1);
    pushWord(lr, w);
    step();
    if (!hold) setValid(1'b0);
  endtask

  task automatic checkWord(input int nbits, input int pulse_at);
    exp_t e;
    for (int b = 0; b < nbits; b++) begin
      checkOutput("scoreboard_has_entry", 16'(sb.size() != 0), 16'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput("si_bit", 16'(si_o), 16'(e.si));
        checkOutput("lr_bit", 16'(lr_o), 16'(e.lr));
        checkOutput("done_bit", 16'(done_o), 16'(e.done));
        checkOutput("ready_bit", 16'(rdy_o), 16'(e.rdy));
        checkOutput("busy_bit", 16'(busy_o), 16'd1);
        dsr = lr_o ? {si_o, dsr[7:1]} : {dsr[6:0], si_o};
        if (e.last) checkOutput("downstream_word", 16'(dsr), 16'(e.word));
      end
      if (b == pulse_at) begin
        din = 8'h00;
        setValid(1'b1);
      end
      step();
      if (b == pulse_at) setValid(1'b0);
    end
  endtask

  task automatic checkGap(input logic lr);
    for (int g = 0; g < 2; g++) begin
      checkOutput("gap_si", 16'(si_o), 16'd0);
      checkOutput("gap_busy", 16'(busy_o), 16'd1);
      checkOutput("gap_lr", 16'(lr_o), 16'(lr));
      checkOutput("gap_ready", 16'(rdy_o), 16'(g == 1));
      step();
    end
  endtask

  task automatic checkIdle();
    checkOutput("idle_busy", 16'(busy_o), 16'd0);
    checkOutput("idle_ready", 16'(rdy_o), 16'd1);
    checkOutput("idle_si", 16'(si_o), 16'd0);
    checkOutput("idle_done", 16'(done_o), 16'd0);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    sel     = 0;
    dsr     = '0;
    rst_n   = 1'b0;
    din     = '0;
    din_lr  = 1'b0;
    valid_a = 1'b0;
    valid_b = 1'b0;

    $display("[TB] reset");
    step();
    step();
    checkOutput("rst_si", 16'(si_a), 16'd0);
    checkOutput("rst_lr", 16'(lr_a), 16'd0);
    checkOutput("rst_busy", 16'(busy_a), 16'd0);
    checkOutput("rst_done", 16'(done_a), 16'd0);
    checkOutput("rst_ready_g2", 16'(rdy_a), 16'd0);
    checkOutput("rst_ready_g0", 16'(rdy_b), 16'd0);
    checkOutput("rst_word_cnt", cnt_a, 16'd0);
    rst_n = 1'b1;
    step();
    checkOutput("release_ready", 16'(rdy_a), 16'd1);

    $display("[TB] A5 left, gap 2");
    applyStimulus(1'b0, 8'hA5, 1'b0);
    checkWord(8, -1);
    checkOutput("cnt_after_a5", cnt_o, 16'd1);
    checkGap(1'b0);
    checkIdle();

    $display("[TB] 01 right, gap 2");
    applyStimulus(1'b1, 8'h01, 1'b0);
    checkWord(8, -1);
    checkOutput("cnt_after_01", cnt_o, 16'd2);
    checkGap(1'b1);
    checkIdle();

    $display("[TB] back-to-back A5 then 3C, gap 0");
    sel = 1;
    checkIdle();
    applyStimulus(1'b0, 8'hA5, 1'b1);
    din    = 8'h3C;
    din_lr = 1'b0;
    pushWord(1'b0, 8'h3C);
    checkWord(8, -1);
    setValid(1'b0);
    checkWord(8, -1);
    checkIdle();
    checkOutput("cnt_back_to_back", cnt_o, 16'd2);

    $display("[TB] reset mid-word");
    sel = 0;
    applyStimulus(1'b0, 8'hFF, 1'b0);
    checkWord(3, -1);
    checkOutput("fourth_bit_si", 16'(si_o), 16'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_si", 16'(si_o), 16'd0);
    checkOutput("midrst_busy", 16'(busy_o), 16'd0);
    checkOutput("midrst_lr", 16'(lr_o), 16'd0);
    checkOutput("midrst_ready", 16'(rdy_o), 16'd0);
    checkOutput("midrst_cnt", cnt_o, 16'd0);
    sb.delete();
    for (int i = 0; i < 6; i++) begin
      step();
      checkOutput("midrst_no_done", 16'(done_o), 16'd0);
    end
    rst_n = 1'b1;
    step();
    checkIdle();
    applyStimulus(1'b1, 8'h5A, 1'b0);
    checkWord(8, -1);
    checkOutput("cnt_after_recover", cnt_o, 16'd1);
    checkGap(1'b1);
    checkIdle();

    $display("[TB] capture and busy-time valid");
    applyStimulus(1'b0, 8'hC3, 1'b0);
    checkWord(8, 3);
    checkGap(1'b0);
    checkIdle();
    step();
    checkIdle();
    checkOutput("cnt_single_word", cnt_o, 16'd2);
    checkOutput("scoreboard_drained", 16'(sb.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
